// File: rtl/log_hist_threshold.sv
// Log2 gradient-magnitude histogram with a percentile scan that picks Canny thresholds.
// Accumulates one frame, scans bins in ascending order, then pulses thr_valid for one cycle.
module log_hist_threshold #(
  parameter int unsigned NBINS   = 10,
  parameter int unsigned COUNT_W = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       log_valid,
  input  logic [3:0] log_in,
  input  logic       log_last,
  input  logic [7:0] pct_num,
  output logic       in_ready,
  output logic       thr_valid,
  output logic [3:0] thr_high,
  output logic [3:0] thr_low
);

  localparam int unsigned CUM_W = COUNT_W + 4;
  localparam int unsigned PROD_W = COUNT_W + 8;
  localparam logic [3:0] LAST_BIN = 4'(NBINS - 1);
  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {StAccum, StScan, StDone} state_t;

  state_t             r_state;
  logic [COUNT_W-1:0] r_bin [NBINS];
  logic [COUNT_W-1:0] r_total;
  logic [COUNT_W-1:0] r_target;
  logic [CUM_W-1:0]   r_cum;
  logic [3:0]         r_k;
  logic               r_in_ready;
  logic               r_thr_valid;
  logic [3:0]         r_thr_high;
  logic [3:0]         r_thr_low;

  logic               w_accept;
  logic [3:0]         w_idx;
  logic [COUNT_W-1:0] w_bin_inc;
  logic [COUNT_W-1:0] w_total_inc;
  logic [PROD_W-1:0]  w_product;
  logic [CUM_W-1:0]   w_cum_next;
  logic               w_hit;
  logic               w_last_k;

  always_comb begin
    w_accept    = log_valid & r_in_ready;
    w_idx       = (log_in > LAST_BIN) ? LAST_BIN : log_in;
    w_bin_inc   = (r_bin[w_idx] == CNT_MAX) ? r_bin[w_idx] : r_bin[w_idx] + 1'b1;
    w_total_inc = (r_total == CNT_MAX) ? r_total : r_total + 1'b1;
    // Target uses the total including the final sample accepted on this edge.
    w_product   = PROD_W'(w_total_inc) * PROD_W'(pct_num);
    w_cum_next  = r_cum + CUM_W'(r_bin[r_k]);
    w_hit       = w_cum_next >= CUM_W'(r_target);
    w_last_k    = (r_k == LAST_BIN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StAccum;
      for (int i = 0; i < int'(NBINS); i++) r_bin[i] <= '0;
      r_total     <= '0;
      r_target    <= '0;
      r_cum       <= '0;
      r_k         <= '0;
      r_in_ready  <= 1'b1;
      r_thr_valid <= 1'b0;
      r_thr_high  <= '0;
      r_thr_low   <= '0;
    end else begin
      r_thr_valid <= 1'b0;
      unique case (r_state)
        StAccum: begin
          if (w_accept) begin
            r_bin[w_idx] <= w_bin_inc;
            r_total      <= w_total_inc;
            if (log_last) begin
              r_target   <= w_product[PROD_W-1:8];
              r_cum      <= '0;
              r_k        <= '0;
              r_in_ready <= 1'b0;
              r_state    <= StScan;
            end
          end
        end
        StScan: begin
          r_cum <= w_cum_next;
          // Falling off the last bin without a hit still reports the top bin.
          if (w_hit || w_last_k) begin
            r_thr_high  <= r_k;
            r_thr_low   <= (r_k == 4'd0) ? 4'd0 : r_k - 4'd1;
            r_thr_valid <= 1'b1;
            r_state     <= StDone;
          end else begin
            r_k <= r_k + 4'd1;
          end
        end
        StDone: begin
          for (int i = 0; i < int'(NBINS); i++) r_bin[i] <= '0;
          r_total    <= '0;
          r_cum      <= '0;
          r_k        <= '0;
          r_in_ready <= 1'b1;
          r_state    <= StAccum;
        end
        default: r_state <= StAccum;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign thr_valid = r_thr_valid;
  assign thr_high  = r_thr_high;
  assign thr_low   = r_thr_low;

endmodule
